mem_bus_agent: RTL and testbench
================================

# mem_bus_agent

Memory-side endpoint of the shared processor/memory bus, sitting directly downstream of the bus controller and consuming its `mem_line` control code while supplying its `mem_ready` request. It holds a small word-addressed memory array. In receive slots it accepts read/write command frames from the processor. In transmit slots it returns queued read data. It raises `mem_ready` whenever read responses are pending.

## Interface
- `DATA_W`, 8: bus and memory word width. The command beat uses bit `DATA_W-1` as the opcode.
- `ADDR_W`, 4: memory address width, giving 2^ADDR_W words. Must satisfy `ADDR_W <= DATA_W-1`.
- `QDEPTH`, 4: read-response queue depth. Must be a power of two.

Ports:
- `clk` in 1: the block's single clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `mem_line` in 2: control code from the bus controller.
  - 00: idle.
  - 01: memory receives.
  - 10: memory transmits.
  - 11: illegal.
- `mem_ready` out 1: registered; high while the response queue is non-empty.
- `bus_in` in DATA_W: processor-to-memory data beat.
- `bus_in_valid` in 1: qualifies `bus_in`.
- `bus_out` out DATA_W: memory-to-processor data. Zero when `bus_out_valid` is low.
- `bus_out_valid` out 1: qualifies `bus_out`.
- `err` out 3: sticky error flags, cleared only by reset.
  - [0]: queue overflow.
  - [1]: incomplete frame.
  - [2]: protocol violation.

## Operation
- **Reset values:**
  - State machine is IDLE; slot counter is 0.
  - Queue is empty; head and tail pointers are 0.
  - `mem_ready`=0, `bus_out`=0, `bus_out_valid`=0, `err`=000.
  - All memory words are 0.
- **States:** IDLE, RX_CMD, RX_DATA, TX, WAIT.
- **In IDLE, `mem_line` is sampled every edge:**
  - 01 → RX_CMD; slot counter loaded with 7.
  - 10 with queue non-empty → TX; slot counter loaded with 7.
  - 10 with queue empty → set `err[2]` and go to WAIT with counter 7. No data is driven.
  - 11 → set `err[2]` and stay in IDLE.
  - 00 → stay in IDLE.
- **Slot counter:**
  - Decrements every edge while not in IDLE.
  - On the edge where it goes from 1 to 0, the machine returns to IDLE from any state. This makes the slot exactly 7 cycles after the grant cycle.
  - Any non-00 `mem_line` seen outside IDLE sets `err[2]` and is otherwise ignored.
- **RX_CMD:**
  - Waits for `bus_in_valid`.
  - Command beat layout: bit `DATA_W-1` is the opcode (1 = write, 0 = read); bits `[ADDR_W-1:0]` are the address; other bits are ignored.
  - Write command: latch the address and go to RX_DATA.
  - Read command: push the address into the queue and go to WAIT. If the queue is full, drop the command and set `err[0]`.
- **RX_DATA:** on `bus_in_valid`, write `mem[addr] <= bus_in` and go to WAIT.
- **Window close:**
  - Closing while in RX_DATA sets `err[1]`; no write occurs.
  - Closing while in RX_CMD is not an error.
- **TX:**
  - For exactly one cycle, drive `bus_out = mem[queue head]` and `bus_out_valid` = 1.
  - At the end of that cycle, pop the queue and go to WAIT.
- **WAIT:** ignores `bus_in_valid` and extra beats until the window closes.
- **`bus_in_valid` in IDLE, WAIT or TX** is ignored.
- **Queue:** circular; pointers are `log2(QDEPTH)` bits plus a wrap bit; full/empty are derived from the pointers. A push and a pop never occur in the same slot.
- **`mem_ready`:** registered from the post-update queue count. It drops on the edge after the pop that empties the queue.
- **Read data:** taken from the array at transmit time, so a write in an intervening slot is visible to an earlier-queued read.

## Timing
- Let the grant code be present in cycle G.
- The agent samples the code at the edge ending G; its slot is G+1..G+7 and it is back in IDLE at the edge ending G+7.
- **TX:**
  - Data is valid in G+1, one cycle of latency after the grant.
  - `mem_ready` reflects the pop from G+2 onward.
- **RX:**
  - The command beat may arrive in any cycle G+1..G+7.
  - The data beat must arrive in a later cycle of the same window.
  - The earliest possible write lands at the edge ending G+2.
  - A read push raises `mem_ready` in the cycle after the command beat.
- **Reset asserted mid-slot:**
  - All outputs return immediately to their reset values, including an in-progress TX beat.
  - Queue contents and memory are lost.

## Test plan
- **Reset:** assert `rst_n`=0 mid-TX → `bus_out_valid`=0, `mem_ready`=0 and `err`=000 without waiting for a clock edge; after release, a read of address 3 returns 0x00.
- **Write then read:**
  - Code 01; beats 0x85 then 0xA5 → `mem[5]`=0xA5.
  - Next slot: code 01, beat 0x05 → `mem_ready`=1 one cycle later.
  - Next slot: code 10 → `bus_out`=0xA5 with valid high for exactly cycle G+1; `mem_ready`=0 from G+2.
- **Overflow:**
  - Five read slots for addresses 0..4 → `mem_ready`=1 and `err`=001.
  - Four TX slots return `mem[0..3]` in order; `mem_ready` falls after the fourth.
- **Incomplete frame:** code 01, beat 0x82, then no further valid in the window → `err[1]`=1 and `mem[2]` unchanged; back in IDLE at G+7.
- **Protocol violations:**
  - `mem_line`=11 in IDLE → `err[2]`=1.
  - Code 10 with empty queue → no `bus_out_valid`, `err[2]`=1.
  - Code 01 at G+3 of an active slot → `err[2]`=1 and the slot still ends at G+7.
- **Window boundary:** command beat in G+7 (read, address 9) → push accepted and `mem_ready`=1; a data beat arriving at G+8 is ignored.

Source files
------------

// File: rtl/mem_bus_agent_if.sv
// Bus bundle between the bus controller/processor side and the memory agent.
// The controller side drives the slot code and inbound beats; the agent answers.
interface mem_bus_agent_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        mem_line;
  logic              mem_ready;
  logic [DATA_W-1:0] bus_in;
  logic              bus_in_valid;
  logic [DATA_W-1:0] bus_out;
  logic              bus_out_valid;
  logic [2:0]        err;

  modport master (
    output mem_line, bus_in, bus_in_valid,
    input  mem_ready, bus_out, bus_out_valid, err
  );

  modport slave (
    input  mem_line, bus_in, bus_in_valid,
    output mem_ready, bus_out, bus_out_valid, err
  );
endinterface

// File: rtl/mem_bus_agent.sv
// Memory-side bus endpoint: accepts read/write frames in receive slots, queues
// read addresses, and returns one word per transmit slot from the array.
module mem_bus_agent #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int QDEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  mem_bus_agent_if.slave bus
);
  localparam int PW    = $clog2(QDEPTH);
  localparam int WORDS = 2 ** ADDR_W;

  typedef enum logic [2:0] {IDLE, RX_CMD, RX_DATA, TX, WAIT} state_t;

  state_t            state, next_state;
  logic [2:0]        cnt, next_cnt;
  logic [DATA_W-1:0] mem [WORDS];
  logic [ADDR_W-1:0] q [QDEPTH];
  logic [PW:0]       wr_ptr, rd_ptr, wr_next, rd_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        err_q, set_err;
  logic              ready_q;
  logic              push, pop, do_write, latch_addr;
  logic              q_empty, q_full;

  assign q_empty = (wr_ptr == rd_ptr);
  assign q_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    push       = 1'b0;
    pop        = 1'b0;
    do_write   = 1'b0;
    latch_addr = 1'b0;
    set_err    = 3'b000;
    if (state == IDLE) begin
      case (bus.mem_line)
        2'b01: begin
          next_state = RX_CMD;
          next_cnt   = 3'd7;
        end
        2'b10: begin
          next_cnt = 3'd7;
          if (!q_empty) begin
            next_state = TX;
          end else begin
            next_state = WAIT;
            set_err[2] = 1'b1;
          end
        end
        2'b11:   set_err[2] = 1'b1;
        default: next_state = IDLE;
      endcase
    end else begin
      next_cnt = cnt - 3'd1;
      if (bus.mem_line != 2'b00) set_err[2] = 1'b1;
      case (state)
        RX_CMD: begin
          if (bus.bus_in_valid) begin
            next_state = WAIT;
            if (bus.bus_in[DATA_W-1]) begin
              latch_addr = 1'b1;
              next_state = RX_DATA;
            end else if (q_full) begin
              set_err[0] = 1'b1;
            end else begin
              push = 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (bus.bus_in_valid) begin
            do_write   = 1'b1;
            next_state = WAIT;
          end
        end
        TX: begin
          pop        = 1'b1;
          next_state = WAIT;
        end
        default: next_state = state;
      endcase
      // Last slot cycle: a write frame still lacking its data beat is incomplete,
      // including one whose command beat arrived in this very cycle.
      if (cnt == 3'd1) begin
        next_state = IDLE;
        if ((state == RX_DATA && !bus.bus_in_valid) || latch_addr) set_err[1] = 1'b1;
      end
    end
  end

  assign wr_next = push ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_next = pop  ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      wr_addr <= '0;
      err_q   <= 3'b000;
      ready_q <= 1'b0;
    end else begin
      wr_ptr  <= wr_next;
      rd_ptr  <= rd_next;
      err_q   <= err_q | set_err;
      ready_q <= (wr_next != rd_next);
      if (latch_addr) wr_addr <= bus.bus_in[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr[PW-1:0]] <= bus.bus_in[ADDR_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[wr_addr] <= bus.bus_in;
    end
  end

  // Read data comes from the array at transmit time, not when the read was queued.
  assign bus.bus_out_valid = (state == TX);
  assign bus.bus_out       = (state == TX) ? mem[q[rd_ptr[PW-1:0]]] : '0;
  assign bus.mem_ready     = ready_q;
  assign bus.err           = err_q;
endmodule

// File: tb/tb_mem_bus_agent.sv
// Directed self-checking bench for mem_bus_agent: one linear sequence of slots
// with hand-computed expectations checked by immediate assertions.
module tb_mem_bus_agent;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  mem_bus_agent_if #(.DATA_W(8)) bus_if ();

  mem_bus_agent #(.DATA_W(8), .ADDR_W(4), .QDEPTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge, mid-cycle.
  task automatic applyStimulus(input logic [1:0] line, input logic [7:0] data, input logic valid);
    @(negedge clk);
    bus_if.mem_line     = line;
    bus_if.bus_in       = data;
    bus_if.bus_in_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(2'b00, 8'h00, 1'b0);
  endtask

  // Receive slot: grant, command in G+1, optional data in G+2, idle to G+7.
  task automatic rxFrame(input logic [7:0] cmd, input logic has_data, input logic [7:0] data,
                         input logic exp_ready, input string tag);
    applyStimulus(2'b01, 8'h00, 1'b0);
    applyStimulus(2'b00, cmd, 1'b1);
    applyStimulus(2'b00, data, has_data);
    checkOutput({tag, " ready"}, 32'(bus_if.mem_ready), 32'(exp_ready));
    idleCycles(5);
  endtask

  // Transmit slot: the beat must be present in G+1 only.
  task automatic txSlot(input logic [7:0] exp_data, input logic exp_ready_after, input string tag);
    applyStimulus(2'b10, 8'h00, 1'b0);
    checkOutput({tag, " valid G"}, 32'(bus_if.bus_out_valid), 32'd0);
    applyStimulus(2'b00, 8'h00, 1'b0);
    checkOutput({tag, " valid G+1"}, 32'(bus_if.bus_out_valid), 32'd1);
    checkOutput({tag, " data G+1"}, 32'(bus_if.bus_out), 32'(exp_data));
    applyStimulus(2'b00, 8'h00, 1'b0);
    checkOutput({tag, " valid G+2"}, 32'(bus_if.bus_out_valid), 32'd0);
    checkOutput({tag, " data G+2"}, 32'(bus_if.bus_out), 32'd0);
    checkOutput({tag, " ready G+2"}, 32'(bus_if.mem_ready), 32'(exp_ready_after));
    idleCycles(5);
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    idleCycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n               = 1'b0;
    bus_if.mem_line     = 2'b00;
    bus_if.bus_in       = 8'h00;
    bus_if.bus_in_valid = 1'b0;

    idleCycles(2);
    checkOutput("reset ready", 32'(bus_if.mem_ready), 32'd0);
    checkOutput("reset valid", 32'(bus_if.bus_out_valid), 32'd0);
    checkOutput("reset data", 32'(bus_if.bus_out), 32'd0);
    checkOutput("reset err", 32'(bus_if.err), 32'd0);
    rst_n = 1'b1;
    idleCycles(1);

    // Write 0xA5 to address 5, queue a read of it, then transmit.
    rxFrame(8'h85, 1'b1, 8'hA5, 1'b0, "wr5");
    rxFrame(8'h05, 1'b0, 8'h00, 1'b1, "rd5");
    txSlot(8'hA5, 1'b0, "tx5");
    checkOutput("err clean", 32'(bus_if.err), 32'd0);

    // Illegal code in IDLE, and the agent must still be idle afterwards.
    applyStimulus(2'b11, 8'h00, 1'b0);
    applyStimulus(2'b00, 8'h00, 1'b0);
    checkOutput("code11 err", 32'(bus_if.err), 32'b100);

    // Reset asserted during the transmit beat clears outputs without a clock edge.
    rxFrame(8'h05, 1'b0, 8'h00, 1'b1, "rd5b");
    applyStimulus(2'b10, 8'h00, 1'b0);
    applyStimulus(2'b00, 8'h00, 1'b0);
    checkOutput("midtx valid", 32'(bus_if.bus_out_valid), 32'd1);
    checkOutput("midtx data", 32'(bus_if.bus_out), 32'hA5);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async valid", 32'(bus_if.bus_out_valid), 32'd0);
    checkOutput("async data", 32'(bus_if.bus_out), 32'd0);
    checkOutput("async ready", 32'(bus_if.mem_ready), 32'd0);
    checkOutput("async err", 32'(bus_if.err), 32'd0);
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(1);
    rxFrame(8'h03, 1'b0, 8'h00, 1'b1, "rd3");
    txSlot(8'h00, 1'b0, "tx3");
    rxFrame(8'h05, 1'b0, 8'h00, 1'b1, "rd5c");
    txSlot(8'h00, 1'b0, "tx5lost");

    // Overflow: fill words 0..3, queue five reads, drain four.
    rxFrame(8'h80, 1'b1, 8'h11, 1'b0, "wr0");
    rxFrame(8'h81, 1'b1, 8'h22, 1'b0, "wr1");
    rxFrame(8'h82, 1'b1, 8'h33, 1'b0, "wr2");
    rxFrame(8'h83, 1'b1, 8'h44, 1'b0, "wr3");
    for (int i = 0; i < 5; i++) rxFrame(8'(i), 1'b0, 8'h00, 1'b1, "rdq");
    checkOutput("overflow err", 32'(bus_if.err), 32'b001);
    txSlot(8'h11, 1'b1, "txq0");
    txSlot(8'h22, 1'b1, "txq1");
    txSlot(8'h33, 1'b1, "txq2");
    txSlot(8'h44, 1'b0, "txq3");

    // Incomplete frame: write command to address 2 with no data beat.
    applyStimulus(2'b01, 8'h00, 1'b0);
    applyStimulus(2'b00, 8'h82, 1'b1);
    idleCycles(6);
    checkOutput("incomplete G+7 err", 32'(bus_if.err), 32'b001);
    applyStimulus(2'b01, 8'h00, 1'b0);
    checkOutput("incomplete closed err", 32'(bus_if.err), 32'b011);
    applyStimulus(2'b00, 8'h02, 1'b1);
    idleCycles(6);
    txSlot(8'h33, 1'b0, "tx2kept");
    checkOutput("idle after close err", 32'(bus_if.err), 32'b011);

    // Transmit grant with an empty queue.
    pulseReset();
    applyStimulus(2'b10, 8'h00, 1'b0);
    applyStimulus(2'b00, 8'h00, 1'b0);
    checkOutput("emptytx valid", 32'(bus_if.bus_out_valid), 32'd0);
    checkOutput("emptytx err", 32'(bus_if.err), 32'b100);
    idleCycles(6);

    // Stray code mid-slot: flagged, but the slot still ends at G+7.
    pulseReset();
    applyStimulus(2'b01, 8'h00, 1'b0);
    applyStimulus(2'b00, 8'h87, 1'b1);
    applyStimulus(2'b00, 8'h00, 1'b0);
    checkOutput("midslot pre err", 32'(bus_if.err), 32'b000);
    applyStimulus(2'b01, 8'h00, 1'b0);
    applyStimulus(2'b00, 8'h5A, 1'b1);
    checkOutput("midslot err", 32'(bus_if.err), 32'b100);
    idleCycles(3);
    rxFrame(8'h07, 1'b0, 8'h00, 1'b1, "rd7");
    txSlot(8'h5A, 1'b0, "tx7");

    // Window boundary: read command in G+7, stray beat in G+8.
    rxFrame(8'h89, 1'b1, 8'h99, 1'b0, "wr9");
    applyStimulus(2'b01, 8'h00, 1'b0);
    idleCycles(6);
    applyStimulus(2'b00, 8'h09, 1'b1);
    applyStimulus(2'b00, 8'hFF, 1'b1);
    checkOutput("boundary ready", 32'(bus_if.mem_ready), 32'd1);
    checkOutput("boundary err", 32'(bus_if.err), 32'b100);
    idleCycles(1);
    txSlot(8'h99, 1'b0, "tx9");
    checkOutput("final err", 32'(bus_if.err), 32'b100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
